gpio_port_bank: RTL and testbench

- Four 8-bit GPIO ports (a, b, c, d) that consume the MCU-side port bus (port_wr_n, port_rd_n, port_addr[6:0], port_wr_data) and return port_rd_data.
- Each port has three registers: port_dir, port_out, and port_in (a synchronized pin image).
- Byte access goes through a register-address window; single-bit access goes through three bit-enable windows.
- Sits directly downstream of the MCU address-decode mux (port space 0x8000–0x807F) and drives the chip-level GPIO pads.

---
 rtl/gpio_port_bank_if.sv | 24 ++
 rtl/gpio_port_bank.sv | 103 ++++++++++
 tb/tb_gpio_port_bank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_port_bank_if.sv
// MCU-side port bus between the address-decode mux and the GPIO bank.
interface gpio_port_bank_if;
    logic       port_wr_n;
    logic       port_rd_n;
    logic [6:0] port_addr;
    logic [7:0] port_wr_data;
    logic [7:0] port_rd_data;

    modport master (
        output port_wr_n,
        output port_rd_n,
        output port_addr,
        output port_wr_data,
        input  port_rd_data
    );

    modport slave (
        input  port_wr_n,
        input  port_rd_n,
        input  port_addr,
        input  port_wr_data,
        output port_rd_data
    );
endinterface

// File: rtl/gpio_port_bank.sv
// Four 8-bit GPIO ports with byte and single-bit register windows.
// Pad inputs are synchronized before they reach the port_in image.
module gpio_port_bank #(
    parameter logic [7:0]  DIR_RST     = 8'h00,
    parameter logic [7:0]  OUT_RST     = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    gpio_port_bank_if.slave        bus,
    input  logic [31:0]            gpio_in,
    output logic [31:0]            gpio_out,
    output logic [31:0]            gpio_oe
);
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 8;
    localparam int unsigned BUS_W     = NUM_PORTS * PORT_W;

    logic [NUM_PORTS-1:0][PORT_W-1:0] r_dir;
    logic [NUM_PORTS-1:0][PORT_W-1:0] r_out;
    logic [BUS_W-1:0]                 r_sync [SYNC_STAGES];
    logic                             r_wr_n_q;

    logic [NUM_PORTS-1:0][PORT_W-1:0] w_pin;
    logic                             w_wr_pulse;
    logic [1:0]                       w_port;
    logic [1:0]                       w_win;
    logic [2:0]                       w_idx;
    logic [PORT_W-1:0]                w_rd_data;

    assign w_port     = bus.port_addr[6:5];
    assign w_win      = bus.port_addr[4:3];
    assign w_idx      = bus.port_addr[2:0];
    assign w_wr_pulse = !bus.port_wr_n && r_wr_n_q;
    assign w_pin      = r_sync[SYNC_STAGES-1];

    // Pad input synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Falling-edge write detect; reset low so a strobe held through reset is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_n_q <= 1'b0;
        end else begin
            r_wr_n_q <= bus.port_wr_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= {NUM_PORTS{DIR_RST}};
            r_out <= {NUM_PORTS{OUT_RST}};
        end else if (w_wr_pulse) begin
            case (w_win)
                2'b00: begin
                    if (w_idx == 3'd0) begin
                        r_dir[w_port] <= bus.port_wr_data;
                    end else if (w_idx == 3'd1) begin
                        r_out[w_port] <= bus.port_wr_data;
                    end
                end
                2'b01:   r_dir[w_port][w_idx] <= bus.port_wr_data[0];
                2'b10:   r_out[w_port][w_idx] <= bus.port_wr_data[0];
                default: ;
            endcase
        end
    end

    // Combinational read decode from current (pre-write) register contents
    always_comb begin
        w_rd_data = 8'h00;
        if (!rst && !bus.port_rd_n) begin
            case (w_win)
                2'b00: begin
                    case (w_idx)
                        3'd0:    w_rd_data = r_dir[w_port];
                        3'd1:    w_rd_data = r_out[w_port];
                        3'd2:    w_rd_data = w_pin[w_port];
                        default: w_rd_data = 8'h00;
                    endcase
                end
                2'b01:   w_rd_data = {7'b0, r_dir[w_port][w_idx]};
                2'b10:   w_rd_data = {7'b0, r_out[w_port][w_idx]};
                default: w_rd_data = {7'b0, w_pin[w_port][w_idx]};
            endcase
        end
    end

    assign bus.port_rd_data = w_rd_data;
    assign gpio_out         = r_out;
    assign gpio_oe          = r_dir;
endmodule

// File: tb/tb_gpio_port_bank.sv
// Randomized plus directed bench for gpio_port_bank against a behavioural model.
module tb_gpio_port_bank;
    localparam int unsigned SYNC = 2;

    logic        clk;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;

    gpio_port_bank_if bus_if ();

    gpio_port_bank #(
        .DIR_RST     (8'h00),
        .OUT_RST     (8'h00),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state: registers per port, pad sample history, write arming
    logic [7:0]  m_dir [4];
    logic [7:0]  m_out [4];
    logic [31:0] m_hist [$];
    bit          m_armed;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_pin(input int p);
        logic [31:0] s;
        s = m_hist[SYNC-1];
        return s[p*8 +: 8];
    endfunction

    function automatic logic [7:0] m_read(input logic r, input logic rdn, input logic [6:0] a);
        int p, w, b;
        logic [7:0] regs [3];
        p = int'(a[6:5]);
        w = int'(a[4:3]);
        b = int'(a[2:0]);
        regs[0] = m_dir[p];
        regs[1] = m_out[p];
        regs[2] = m_pin(p);
        if (r || rdn) return 8'h00;
        if (w == 0) return (b < 3) ? regs[b] : 8'h00;
        return {7'b0, regs[w-1][b]};
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] v [4]);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    // Model update on every clock edge, reset asynchronously
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    m_dir[i] = 8'h00;
                    m_out[i] = 8'h00;
                end
                m_hist  = {};
                for (int i = 0; i < int'(SYNC); i++) m_hist.push_back(32'h0);
                m_armed = 1'b0;
            end else begin
                if (!bus_if.port_wr_n && m_armed) begin
                    int p, w, b;
                    logic [7:0] d;
                    p = int'(bus_if.port_addr[6:5]);
                    w = int'(bus_if.port_addr[4:3]);
                    b = int'(bus_if.port_addr[2:0]);
                    d = bus_if.port_wr_data;
                    if (w == 0 && b == 0) m_dir[p] = d;
                    else if (w == 0 && b == 1) m_out[p] = d;
                    else if (w == 1) m_dir[p][b] = d[0];
                    else if (w == 2) m_out[p][b] = d[0];
                end
                m_armed = bus_if.port_wr_n;
                m_hist.push_front(gpio_in);
                void'(m_hist.pop_back());
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("gpio_out", gpio_out, pack(m_out));
                chk("gpio_oe", gpio_oe, pack(m_dir));
                chk("rd_data", {24'h0, bus_if.port_rd_data},
                    {24'h0, m_read(rst, bus_if.port_rd_n, bus_if.port_addr)});
            end
        end
    end

    task automatic step(input logic wrn, input logic rdn, input logic [6:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus_if.port_wr_n    = wrn;
        bus_if.port_rd_n    = rdn;
        bus_if.port_addr    = a;
        bus_if.port_wr_data = d;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
        step(1'b1, 1'b1, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
        step(1'b1, 1'b0, a, 8'h00);
        @(negedge clk);
        chk(name, {24'h0, bus_if.port_rd_data}, {24'h0, exp});
    endtask

    initial begin
        rst                 = 1'b1;
        gpio_in             = 32'h0;
        bus_if.port_wr_n    = 1'b1;
        bus_if.port_rd_n    = 1'b1;
        bus_if.port_addr    = 7'h00;
        bus_if.port_wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset state
        rd_chk("rst_rd00", 7'h00, 8'h00);
        chk("rst_oe", gpio_oe, 32'h0);
        chk("rst_out", gpio_out, 32'h0);

        // Byte write held low 5 cycles; data changes during hold must not land
        step(1'b0, 1'b1, 7'h21, 8'hA5);
        step(1'b0, 1'b1, 7'h21, 8'h00);
        @(negedge clk);
        chk("bytewr_first", {24'h0, gpio_out[15:8]}, 32'hA5);
        repeat (3) step(1'b0, 1'b1, 7'h21, 8'h00);
        step(1'b1, 1'b1, 7'h21, 8'h00);
        @(negedge clk);
        chk("bytewr_hold", gpio_out, 32'h0000A500);
        rd_chk("bytewr_rd", 7'h21, 8'hA5);

        // Read and write same location in one cycle returns pre-write value
        step(1'b0, 1'b0, 7'h21, 8'h5A);
        @(negedge clk);
        chk("rw_same_pre", {24'h0, bus_if.port_rd_data}, 32'hA5);
        rd_chk("rw_same_post", 7'h21, 8'h5A);

        // Bit access on port c dir
        wr(7'h40, 8'h0F);
        wr(7'h4F, 8'h01);
        @(negedge clk);
        chk("bit_set7", {24'h0, gpio_oe[23:16]}, 32'h8F);
        wr(7'h48, 8'hFE);
        @(negedge clk);
        chk("bit_clr0", {24'h0, gpio_oe[23:16]}, 32'h8E);
        rd_chk("bit_rd7", 7'h4F, 8'h01);
        rd_chk("bit_rd0", 7'h48, 8'h00);

        // Input synchronizer latency on port d
        step(1'b1, 1'b0, 7'h62, 8'h00);
        gpio_in[31:24] = 8'h3C;
        @(negedge clk);
        chk("sync_0", {24'h0, bus_if.port_rd_data}, 32'h00);
        rd_chk("sync_1", 7'h62, 8'h00);
        rd_chk("sync_2", 7'h62, 8'h3C);
        rd_chk("sync_bit2", 7'h7A, 8'h01);
        rd_chk("sync_bit1", 7'h79, 8'h00);
        wr(7'h62, 8'hFF);
        wr(7'h7A, 8'h00);
        rd_chk("in_ro_byte", 7'h62, 8'h3C);
        rd_chk("in_ro_bit", 7'h7A, 8'h01);

        // Back-to-back strobes separated by one high cycle
        wr(7'h00, 8'h11);
        @(negedge clk);
        chk("b2b_first", {24'h0, gpio_oe[7:0]}, 32'h11);
        wr(7'h00, 8'h22);
        @(negedge clk);
        chk("b2b_second", {24'h0, gpio_oe[7:0]}, 32'h22);

        // Reserved and idle reads
        rd_chk("resv_rd07", 7'h07, 8'h00);
        rd_chk("resv_rd05", 7'h05, 8'h00);
        wr(7'h03, 8'hFF);
        @(negedge clk);
        chk("resv_wr_oe", gpio_oe, 32'h008E0022);
        chk("resv_wr_out", gpio_out, 32'h00005A00);
        step(1'b1, 1'b1, 7'h00, 8'h00);
        @(negedge clk);
        chk("idle_rd", {24'h0, bus_if.port_rd_data}, 32'h00);

        // Reset during a strobe; strobe still low after release must not write
        step(1'b0, 1'b1, 7'h00, 8'h77);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_oe", gpio_oe, 32'h0);
        chk("mid_rst_out", gpio_out, 32'h0);
        step(1'b0, 1'b0, 7'h00, 8'h77);
        @(negedge clk);
        chk("mid_rst_rd", {24'h0, bus_if.port_rd_data}, 32'h00);
        step(1'b0, 1'b0, 7'h00, 8'h77);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b1, 7'h00, 8'h77);
        @(negedge clk);
        chk("post_rst_nowr", gpio_oe, 32'h0);
        step(1'b1, 1'b1, 7'h00, 8'h00);
        wr(7'h00, 8'h33);
        @(negedge clk);
        chk("post_rst_rearm", {24'h0, gpio_oe[7:0]}, 32'h33);

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 7'($urandom),
                 8'($urandom));
            if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
        end

        step(1'b1, 1'b1, 7'h00, 8'h00);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
